// File: rtl/gmii_line_ctrl.sv
// gmii_line_ctrl: write-side sequencer from the GMII packet receiver into a
// two-bank ping-pong video line RAM. Each packet carries one half line; the
// two halves of a line are paired in the bank being filled. Completed lines
// are offered to the scan-out side in completion order through valid/ack.
// Packets with nowhere to go are dropped. Short packets and abandoned partial
// lines are counted as errors.
module gmii_line_ctrl #(
   parameter int WORDS_PER_HALF = 640,
   parameter int ADDR_W         = 11,
   parameter int CNT_W          = 16
) (
   input  logic              i_clk125,
   input  logic              i_sys_rst_n,
   input  logic [28:0]       i_din,
   input  logic              i_din_en,
   input  logic              i_pkt_en,
   output logic              o_buf_we,
   output logic              o_buf_bank,
   output logic [ADDR_W-1:0] o_buf_addr,
   output logic [15:0]       o_buf_wdata,
   output logic              o_line_valid,
   output logic              o_line_bank,
   output logic [10:0]       o_line_y,
   input  logic              i_line_ack,
   output logic [CNT_W-1:0]  o_drop_cnt,
   output logic [CNT_W-1:0]  o_err_cnt
);

   localparam logic [ADDR_W-1:0] LP_LAST_IDX  = ADDR_W'(WORDS_PER_HALF - 1);
   localparam logic [ADDR_W-1:0] LP_HALF_BASE = ADDR_W'(WORDS_PER_HALF);
   localparam logic [ADDR_W-1:0] LP_ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  LP_CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  LP_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FILL = 2'd1,
      ST_DONE = 2'd2,
      ST_SKIP = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_fill_bank;
   logic                r_rd_bank;
   logic [1:0]          r_ready;
   logic [1:0]          r_half_mask;
   logic [10:0]         r_tag_y [2];
   logic [ADDR_W-1:0]   r_wcnt;
   logic                r_x_half;
   logic                r_cmpl_pend;
   logic                r_cmpl_bank;

   logic                r_buf_we;
   logic                r_buf_bank;
   logic [ADDR_W-1:0]   r_buf_addr;
   logic [15:0]         r_buf_wdata;
   logic [CNT_W-1:0]    r_drop_cnt;
   logic [CNT_W-1:0]    r_err_cnt;

   logic                w_x_in;
   logic [10:0]         w_y_in;
   logic [15:0]         w_pix_in;
   logic                w_unused_din;

   logic                w_ack;
   logic [1:0]          w_ready_acked;
   logic [1:0]          w_ready_nxt;
   logic                w_bank_busy;

   logic                w_wr_en;
   logic [ADDR_W-1:0]   w_wr_idx;
   logic                w_wr_x;
   logic [ADDR_W-1:0]   w_wr_addr;
   logic                w_drop;
   logic                w_abandon;
   logic                w_abort;
   logic                w_tag_load;
   logic                w_last;
   logic [1:0]          w_mask_base;
   logic [1:0]          w_mask_set;
   logic [1:0]          w_mask_nxt;
   logic                w_complete;

   assign w_x_in       = i_din[27];
   assign w_y_in       = i_din[26:16];
   assign w_pix_in     = i_din[15:0];
   assign w_unused_din = i_din[28];

   // An ack only counts while a line is actually on offer.
   assign w_ack = i_line_ack && r_ready[r_rd_bank];

   // Ready flags after this cycle's ack and any completion landing in RAM now.
   always_comb begin
      w_ready_acked = r_ready;
      if (w_ack) begin
         w_ready_acked[r_rd_bank] = 1'b0;
      end else begin
         w_ready_acked = r_ready;
      end
      w_ready_nxt = w_ready_acked;
      if (r_cmpl_pend) begin
         w_ready_nxt[r_cmpl_bank] = 1'b1;
      end else begin
         w_ready_nxt = w_ready_acked;
      end
   end

   // A bank released by an ack in this same cycle is already free to fill.
   assign w_bank_busy = w_ready_acked[r_fill_bank];

   // State register.
   always_ff @(posedge i_clk125 or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (i_din_en && i_pkt_en) begin
               if (w_bank_busy) begin
                  w_state_nxt = ST_SKIP;
               end else if (w_last) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt = ST_FILL;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_FILL: begin
            if (!i_pkt_en) begin
               w_state_nxt = ST_IDLE;
            end else if (w_last) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_FILL;
            end
         end
         ST_DONE, ST_SKIP: begin
            if (!i_pkt_en) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = r_state;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Per-cycle datapath actions decoded from state and inputs.
   always_comb begin
      w_wr_en    = 1'b0;
      w_wr_idx   = r_wcnt;
      w_wr_x     = r_x_half;
      w_drop     = 1'b0;
      w_abandon  = 1'b0;
      w_abort    = 1'b0;
      w_tag_load = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_din_en && i_pkt_en) begin
               if (w_bank_busy) begin
                  w_drop = 1'b1;
               end else begin
                  w_tag_load = 1'b1;
                  w_abandon  = (r_half_mask != 2'b00) && (w_y_in != r_tag_y[r_fill_bank]);
                  w_wr_en    = 1'b1;
                  w_wr_idx   = {ADDR_W{1'b0}};
                  w_wr_x     = w_x_in;
               end
            end else begin
               w_wr_en = 1'b0;
            end
         end
         ST_FILL: begin
            if (!i_pkt_en) begin
               w_abort = 1'b1;
            end else if (i_din_en) begin
               w_wr_en = 1'b1;
            end else begin
               w_wr_en = 1'b0;
            end
         end
         default: w_wr_en = 1'b0;
      endcase
   end

   assign w_wr_addr   = (w_wr_x ? LP_HALF_BASE : {ADDR_W{1'b0}}) + w_wr_idx;
   assign w_last      = w_wr_en && (w_wr_idx == LP_LAST_IDX);
   assign w_mask_base = w_abandon ? 2'b00 : r_half_mask;
   assign w_mask_set  = w_mask_base | (2'b01 << w_wr_x);
   assign w_complete  = w_last && (w_mask_set == 2'b11);

   // Half mask: record a finished half, clear on line completion or abandon.
   always_comb begin
      if (w_complete) begin
         w_mask_nxt = 2'b00;
      end else if (w_last) begin
         w_mask_nxt = w_mask_set;
      end else begin
         w_mask_nxt = w_mask_base;
      end
   end

   // Line bookkeeping: fill/read banks, tags, word index, ready flags.
   always_ff @(posedge i_clk125 or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         r_fill_bank <= 1'b0;
         r_rd_bank   <= 1'b0;
         r_ready     <= 2'b00;
         r_half_mask <= 2'b00;
         r_tag_y[0]  <= 11'd0;
         r_tag_y[1]  <= 11'd0;
         r_wcnt      <= {ADDR_W{1'b0}};
         r_x_half    <= 1'b0;
         r_cmpl_pend <= 1'b0;
         r_cmpl_bank <= 1'b0;
      end else begin
         r_half_mask <= w_mask_nxt;
         r_ready     <= w_ready_nxt;
         r_cmpl_pend <= w_complete;
         if (w_tag_load) begin
            r_tag_y[r_fill_bank] <= w_y_in;
         end
         if (w_wr_en) begin
            r_wcnt   <= w_wr_idx + LP_ADDR_ONE;
            r_x_half <= w_wr_x;
         end
         // Ready is raised one cycle later, when the final word reaches RAM.
         if (w_complete) begin
            r_cmpl_bank <= r_fill_bank;
            r_fill_bank <= ~r_fill_bank;
         end
         if (w_ack) begin
            r_rd_bank <= ~r_rd_bank;
         end
      end
   end

   // Registered RAM write port and saturating drop/error counters.
   always_ff @(posedge i_clk125 or negedge i_sys_rst_n) begin
      if (!i_sys_rst_n) begin
         r_buf_we    <= 1'b0;
         r_buf_bank  <= 1'b0;
         r_buf_addr  <= {ADDR_W{1'b0}};
         r_buf_wdata <= 16'd0;
         r_drop_cnt  <= {CNT_W{1'b0}};
         r_err_cnt   <= {CNT_W{1'b0}};
      end else begin
         r_buf_we <= w_wr_en;
         if (w_wr_en) begin
            r_buf_bank  <= r_fill_bank;
            r_buf_addr  <= w_wr_addr;
            r_buf_wdata <= w_pix_in;
         end
         if (w_drop && (r_drop_cnt != LP_CNT_MAX)) begin
            r_drop_cnt <= r_drop_cnt + LP_CNT_ONE;
         end
         if ((w_abandon || w_abort) && (r_err_cnt != LP_CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + LP_CNT_ONE;
         end
      end
   end

   assign o_buf_we     = r_buf_we;
   assign o_buf_bank   = r_buf_bank;
   assign o_buf_addr   = r_buf_addr;
   assign o_buf_wdata  = r_buf_wdata;
   assign o_line_valid = r_ready[r_rd_bank];
   assign o_line_bank  = r_rd_bank;
   assign o_line_y     = r_tag_y[r_rd_bank];
   assign o_drop_cnt   = r_drop_cnt;
   assign o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_gmii_line_ctrl.sv
// tb_gmii_line_ctrl: directed packet table, hand sequences for reset and
// same-cycle ack/start, then random packets checked against a packet-level
// model of the line pairing rules.
module tb_gmii_line_ctrl;

   localparam int WPH    = 640;
   localparam int OP_PKT = 0;
   localparam int OP_ACK = 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [28:0] din;
   logic        din_en, pkt_en, line_ack;
   logic        buf_we, buf_bank, line_valid, line_bank;
   logic [10:0] buf_addr, line_y;
   logic [15:0] buf_wdata, drop_cnt, err_cnt;

   gmii_line_ctrl dut (
      .i_clk125     (clk),
      .i_sys_rst_n  (rst_n),
      .i_din        (din),
      .i_din_en     (din_en),
      .i_pkt_en     (pkt_en),
      .o_buf_we     (buf_we),
      .o_buf_bank   (buf_bank),
      .o_buf_addr   (buf_addr),
      .o_buf_wdata  (buf_wdata),
      .o_line_valid (line_valid),
      .o_line_bank  (line_bank),
      .o_line_y     (line_y),
      .i_line_ack   (line_ack),
      .o_drop_cnt   (drop_cnt),
      .o_err_cnt    (err_cnt)
   );

   always #4 clk = ~clk;

   typedef struct {
      logic        bank;
      logic [10:0] addr;
      logic [15:0] data;
   } wr_t;

   typedef struct {
      int          op;
      bit          x;
      logic [10:0] y;
      int          n;
      bit          exp_valid;
      bit          exp_lbank;
      logic [10:0] exp_ly;
      int          exp_drop;
      int          exp_err;
      int          exp_nwr;
      bit          exp_wbank;
      bit          chk_rise;
   } vec_t;

   typedef struct {
      bit          bank;
      logic [10:0] y;
   } line_t;

   wr_t         wr_q[$];
   logic [15:0] drv_pix [WPH];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          last_we_cyc = -1;
   int          valid_rise_cyc = -1;
   bit          prev_valid = 1'b0;

   // packet-level reference model
   line_t       m_q[$];
   bit          m_fill;
   logic [1:0]  m_mask;
   logic [10:0] m_tag [2];
   int          m_drop, m_err;

   // Monitor: capture RAM writes and the cycle line_valid rises.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (buf_we) begin
         wr_q.push_back('{buf_bank, buf_addr, buf_wdata});
         last_we_cyc = cyc;
      end
      if (line_valid && !prev_valid) valid_rise_cyc = cyc;
      prev_valid = line_valid;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic check_writes(input string nm, input int exp_n, input bit exp_bank, input bit x);
      int nbad;
      int first;
      int ea;
      nbad  = 0;
      first = -1;
      if (wr_q.size() != exp_n) nbad++;
      foreach (wr_q[i]) begin
         if (i < WPH) begin
            ea = x * WPH + i;
            if (wr_q[i].bank != exp_bank || wr_q[i].addr != 11'(ea) || wr_q[i].data != drv_pix[i]) begin
               if (first < 0) first = i;
               nbad++;
            end
         end
      end
      total++;
      if (nbad != 0) begin
         bad++;
         $display("FAIL %s: got %0d writes want %0d to bank %0d, %0d bad entries, first bad index %0d",
                  nm, wr_q.size(), exp_n, exp_bank, nbad, first);
      end
      wr_q.delete();
   endtask

   task automatic check_state(input string nm, input bit v, input bit lb, input logic [10:0] ly,
                              input int dr, input int er);
      chk({nm, "_valid"}, int'(line_valid), int'(v));
      if (v) begin
         chk({nm, "_lbank"}, int'(line_bank), int'(lb));
         chk({nm, "_ly"}, int'(line_y), int'(ly));
      end
      chk({nm, "_drop"}, int'(drop_cnt), dr);
      chk({nm, "_err"}, int'(err_cnt), er);
   endtask

   task automatic send_pkt(input bit x, input logic [10:0] y, input int n, input bit gaps, input bit ack_first);
      int          sent;
      logic [15:0] pix;
      sent   = 0;
      pkt_en = 1'b1;
      while (sent < n) begin
         if (gaps && sent > 0 && $urandom_range(0, 7) == 0) begin
            din_en = 1'b0;
            tick();
         end else begin
            pix = gaps ? 16'($urandom) : 16'(sent);
            drv_pix[sent] = pix;
            din      = {1'b0, x, y, pix};
            din_en   = 1'b1;
            line_ack = ack_first && (sent == 0);
            tick();
            line_ack = 1'b0;
            sent++;
         end
      end
      din_en = 1'b0;
      if (n >= WPH) begin
         if ($urandom_range(0, 1) == 1) begin
            din    = 29'($urandom);
            din_en = 1'b1;
            tick();
            din_en = 1'b0;
         end
         tick();
      end
      pkt_en = 1'b0;
      repeat (3) tick();
   endtask

   task automatic do_ack();
      line_ack = 1'b1;
      tick();
      line_ack = 1'b0;
      tick();
   endtask

   task automatic model_reset();
      m_q.delete();
      m_fill = 1'b0;
      m_mask = 2'b00;
      m_tag[0] = 11'd0;
      m_tag[1] = 11'd0;
      m_drop = 0;
      m_err  = 0;
   endtask

   task automatic model_pkt(input bit x, input logic [10:0] y, input int n, output int nwr, output bit wb);
      bit busy;
      busy = 1'b0;
      foreach (m_q[i]) if (m_q[i].bank == m_fill) busy = 1'b1;
      wb  = m_fill;
      nwr = 0;
      if (busy) begin
         m_drop++;
      end else begin
         if (m_mask != 2'b00 && y != m_tag[m_fill]) begin
            m_err++;
            m_mask = 2'b00;
         end
         m_tag[m_fill] = y;
         nwr = n;
         if (n < WPH) begin
            m_err++;
         end else begin
            m_mask[x] = 1'b1;
            if (m_mask == 2'b11) begin
               m_q.push_back('{m_fill, y});
               m_mask = 2'b00;
               m_fill = ~m_fill;
            end
         end
      end
   endtask

   vec_t tbl [23];

   initial begin
      int          nwr;
      bit          wb;
      bit          rx;
      logic [10:0] ry;
      int          rn;
      line_t       hd;

      tbl[0]  = '{OP_PKT, 1'b0, 11'd5,  640, 1'b0, 1'b0, 11'd0,  0, 0, 640, 1'b0, 1'b0};
      tbl[1]  = '{OP_PKT, 1'b1, 11'd5,  640, 1'b1, 1'b0, 11'd5,  0, 0, 640, 1'b0, 1'b1};
      tbl[2]  = '{OP_ACK, 1'b0, 11'd0,  0,   1'b0, 1'b1, 11'd0,  0, 0, 0,   1'b0, 1'b0};
      tbl[3]  = '{OP_PKT, 1'b1, 11'd7,  640, 1'b0, 1'b1, 11'd0,  0, 0, 640, 1'b1, 1'b0};
      tbl[4]  = '{OP_PKT, 1'b0, 11'd7,  640, 1'b1, 1'b1, 11'd7,  0, 0, 640, 1'b1, 1'b1};
      tbl[5]  = '{OP_PKT, 1'b0, 11'd8,  640, 1'b1, 1'b1, 11'd7,  0, 0, 640, 1'b0, 1'b0};
      tbl[6]  = '{OP_PKT, 1'b1, 11'd8,  640, 1'b1, 1'b1, 11'd7,  0, 0, 640, 1'b0, 1'b0};
      tbl[7]  = '{OP_PKT, 1'b0, 11'd9,  640, 1'b1, 1'b1, 11'd7,  1, 0, 0,   1'b0, 1'b0};
      tbl[8]  = '{OP_ACK, 1'b0, 11'd0,  0,   1'b1, 1'b0, 11'd8,  1, 0, 0,   1'b0, 1'b0};
      tbl[9]  = '{OP_ACK, 1'b0, 11'd0,  0,   1'b0, 1'b1, 11'd0,  1, 0, 0,   1'b0, 1'b0};
      tbl[10] = '{OP_ACK, 1'b0, 11'd0,  0,   1'b0, 1'b1, 11'd0,  1, 0, 0,   1'b0, 1'b0};
      tbl[11] = '{OP_PKT, 1'b0, 11'd10, 100, 1'b0, 1'b1, 11'd0,  1, 1, 100, 1'b1, 1'b0};
      tbl[12] = '{OP_PKT, 1'b0, 11'd10, 640, 1'b0, 1'b1, 11'd0,  1, 1, 640, 1'b1, 1'b0};
      tbl[13] = '{OP_PKT, 1'b1, 11'd10, 640, 1'b1, 1'b1, 11'd10, 1, 1, 640, 1'b1, 1'b1};
      tbl[14] = '{OP_ACK, 1'b0, 11'd0,  0,   1'b0, 1'b0, 11'd0,  1, 1, 0,   1'b0, 1'b0};
      tbl[15] = '{OP_PKT, 1'b0, 11'd3,  640, 1'b0, 1'b0, 11'd0,  1, 1, 640, 1'b0, 1'b0};
      tbl[16] = '{OP_PKT, 1'b1, 11'd4,  640, 1'b0, 1'b0, 11'd0,  1, 2, 640, 1'b0, 1'b0};
      tbl[17] = '{OP_PKT, 1'b0, 11'd4,  640, 1'b1, 1'b0, 11'd4,  1, 2, 640, 1'b0, 1'b1};
      tbl[18] = '{OP_PKT, 1'b1, 11'd6,  640, 1'b1, 1'b0, 11'd4,  1, 2, 640, 1'b1, 1'b0};
      tbl[19] = '{OP_PKT, 1'b1, 11'd6,  640, 1'b1, 1'b0, 11'd4,  1, 2, 640, 1'b1, 1'b0};
      tbl[20] = '{OP_PKT, 1'b0, 11'd6,  640, 1'b1, 1'b0, 11'd4,  1, 2, 640, 1'b1, 1'b0};
      tbl[21] = '{OP_ACK, 1'b0, 11'd0,  0,   1'b1, 1'b1, 11'd6,  1, 2, 0,   1'b0, 1'b0};
      tbl[22] = '{OP_ACK, 1'b0, 11'd0,  0,   1'b0, 1'b0, 11'd0,  1, 2, 0,   1'b0, 1'b0};

      rst_n = 1'b0; din = 29'd0; din_en = 1'b0; pkt_en = 1'b0; line_ack = 1'b0;
      repeat (3) tick();
      chk("rst_buf_we", int'(buf_we), 0);
      chk("rst_buf_addr", int'(buf_addr), 0);
      chk("rst_line_valid", int'(line_valid), 0);
      chk("rst_line_bank", int'(line_bank), 0);
      chk("rst_drop", int'(drop_cnt), 0);
      chk("rst_err", int'(err_cnt), 0);
      rst_n = 1'b1;
      tick();

      // directed table
      for (int r = 0; r < 23; r++) begin
         if (tbl[r].op == OP_PKT) begin
            send_pkt(tbl[r].x, tbl[r].y, tbl[r].n, 1'b0, 1'b0);
            check_writes($sformatf("row%0d_wr", r), tbl[r].exp_nwr, tbl[r].exp_wbank, tbl[r].x);
            if (tbl[r].chk_rise) chk($sformatf("row%0d_rise", r), valid_rise_cyc, last_we_cyc + 1);
         end else begin
            do_ack();
         end
         chk($sformatf("row%0d_linebank", r), int'(line_bank), int'(tbl[r].exp_lbank));
         check_state($sformatf("row%0d", r), tbl[r].exp_valid, tbl[r].exp_lbank, tbl[r].exp_ly,
                     tbl[r].exp_drop, tbl[r].exp_err);
      end

      // reset in the middle of a fill
      pkt_en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         din = {1'b0, 1'b0, 11'd11, 16'(i)};
         din_en = 1'b1;
         tick();
      end
      chk("midrst_pre_we", int'(buf_we), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_we", int'(buf_we), 0);
      chk("midrst_addr", int'(buf_addr), 0);
      chk("midrst_wdata", int'(buf_wdata), 0);
      chk("midrst_drop", int'(drop_cnt), 0);
      chk("midrst_err", int'(err_cnt), 0);
      din_en = 1'b0; pkt_en = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      wr_q.delete();
      send_pkt(1'b0, 11'd12, WPH, 1'b0, 1'b0);
      check_writes("postrst_x0_wr", WPH, 1'b0, 1'b0);
      send_pkt(1'b1, 11'd12, WPH, 1'b0, 1'b0);
      check_writes("postrst_x1_wr", WPH, 1'b0, 1'b1);
      check_state("postrst", 1'b1, 1'b0, 11'd12, 0, 0);

      // ack frees a bank in the cycle a new packet starts
      send_pkt(1'b0, 11'd13, WPH, 1'b0, 1'b0);
      check_writes("fill1_x0_wr", WPH, 1'b1, 1'b0);
      send_pkt(1'b1, 11'd13, WPH, 1'b0, 1'b0);
      check_writes("fill1_x1_wr", WPH, 1'b1, 1'b1);
      send_pkt(1'b0, 11'd14, WPH, 1'b0, 1'b1);
      check_writes("ackstart_wr", WPH, 1'b0, 1'b0);
      check_state("ackstart", 1'b1, 1'b1, 11'd13, 0, 0);
      send_pkt(1'b1, 11'd14, WPH, 1'b0, 1'b0);
      check_writes("ackstart_x1_wr", WPH, 1'b0, 1'b1);
      do_ack();
      check_state("ackstart_next", 1'b1, 1'b0, 11'd14, 0, 0);

      // random packets against the model
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      wr_q.delete();
      model_reset();
      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 9) < 3) begin
            do_ack();
            if (m_q.size() > 0) void'(m_q.pop_front());
         end else begin
            rx = 1'($urandom_range(0, 1));
            ry = 11'(20 + $urandom_range(0, 1));
            rn = ($urandom_range(0, 5) == 0) ? $urandom_range(1, WPH - 1) : WPH;
            send_pkt(rx, ry, rn, 1'b1, 1'b0);
            model_pkt(rx, ry, rn, nwr, wb);
            check_writes($sformatf("rnd%0d_wr", k), nwr, wb, rx);
         end
         if (m_q.size() > 0) begin
            hd = m_q[0];
            check_state($sformatf("rnd%0d", k), 1'b1, hd.bank, hd.y, m_drop, m_err);
         end else begin
            check_state($sformatf("rnd%0d", k), 1'b0, 1'b0, 11'd0, m_drop, m_err);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
